axi_lite_write_router: RTL and testbench

// - Write-channel router downstream of axi_lite_decoder: consumes its one-hot o_slave_select_write, steers one master's AW/W to the selected slave, returns that slave's B.
// - One transaction in flight. Zero-hot or multi-hot select is answered locally with DECERR; slaves see nothing.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/axi_lite_write_router.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_write_router.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, write-router state encoding and
// a one-hot test used by the router's decode step.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        FWD    = 3'd2,
        RESP   = 3'd3,
        DERR   = 3'd4,
        MRESP  = 3'd5
    } router_state_e;

    // Exactly one bit set; callers zero-extend narrower selects to 32 bits.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/axi_lite_write_router.sv
// AXI-Lite write-channel router: steers one master's AW/W to the one-hot
// selected slave and returns its B; bad selects are answered locally with DECERR.
module axi_lite_write_router
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SLAVES-1:0]     i_slave_select,
    input  logic [ADDR_WIDTH-1:0]     i_m_awaddr,
    input  logic                      i_m_awvalid,
    output logic                      o_m_awready,
    input  logic [DATA_WIDTH-1:0]     i_m_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_m_wstrb,
    input  logic                      i_m_wvalid,
    output logic                      o_m_wready,
    output logic [1:0]                o_m_bresp,
    output logic                      o_m_bvalid,
    input  logic                      i_m_bready,
    output logic [ADDR_WIDTH-1:0]     o_s_awaddr,
    output logic [NUM_SLAVES-1:0]     o_s_awvalid,
    input  logic [NUM_SLAVES-1:0]     i_s_awready,
    output logic [DATA_WIDTH-1:0]     o_s_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_s_wstrb,
    output logic [NUM_SLAVES-1:0]     o_s_wvalid,
    input  logic [NUM_SLAVES-1:0]     i_s_wready,
    input  logic [2*NUM_SLAVES-1:0]   i_s_bresp,
    input  logic [NUM_SLAVES-1:0]     i_s_bvalid,
    output logic [NUM_SLAVES-1:0]     o_s_bready,
    output logic [CNT_WIDTH-1:0]      o_decerr_cnt
);

    router_state_e             state_q, state_d;
    logic [NUM_SLAVES-1:0]     sel_q, sel_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic                      m_awready_s;
    logic                      m_wready_s;
    logic [NUM_SLAVES-1:0]     s_awvalid_s;
    logic [NUM_SLAVES-1:0]     s_wvalid_s;
    logic [NUM_SLAVES-1:0]     s_bready_s;
    logic                      sel_bvalid_s;
    logic [1:0]                sel_bresp_s;

    assign o_s_awaddr   = i_m_awaddr;
    assign o_s_wdata    = i_m_wdata;
    assign o_s_wstrb    = i_m_wstrb;
    assign o_m_awready  = m_awready_s;
    assign o_m_wready   = m_wready_s;
    assign o_s_awvalid  = s_awvalid_s;
    assign o_s_wvalid   = s_wvalid_s;
    assign o_s_bready   = s_bready_s;
    assign o_m_bvalid   = bvalid_q;
    assign o_m_bresp    = bresp_q;
    assign o_decerr_cnt = cnt_q;

    // B-channel mux: sel_q is one-hot whenever it is consulted, so OR-ing is exact.
    always_comb begin
        sel_bvalid_s = 1'b0;
        sel_bresp_s  = RESP_OKAY;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            sel_bvalid_s = sel_bvalid_s | (sel_q[k] & i_s_bvalid[k]);
            sel_bresp_s  = sel_bresp_s | ({2{sel_q[k]}} & i_s_bresp[2*k +: 2]);
        end
    end

    // Next-state and combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        cnt_d       = cnt_q;
        m_awready_s = 1'b0;
        m_wready_s  = 1'b0;
        s_awvalid_s = '0;
        s_wvalid_s  = '0;
        s_bready_s  = '0;

        case (state_q)
            IDLE: begin
                if (i_m_awvalid) begin
                    state_d = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                sel_d = i_slave_select;
                if (is_onehot(32'(i_slave_select))) begin
                    state_d = FWD;
                end else begin
                    state_d = DERR;
                end
            end
            FWD: begin
                s_awvalid_s = sel_q & {NUM_SLAVES{i_m_awvalid & ~aw_done_q}};
                s_wvalid_s  = sel_q & {NUM_SLAVES{i_m_wvalid & ~w_done_q}};
                m_awready_s = (|(i_s_awready & sel_q)) & ~aw_done_q;
                m_wready_s  = (|(i_s_wready & sel_q)) & ~w_done_q;
                aw_done_d   = aw_done_q | (i_m_awvalid & m_awready_s);
                w_done_d    = w_done_q | (i_m_wvalid & m_wready_s);
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end else begin
                    state_d = FWD;
                end
            end
            RESP: begin
                s_bready_s = sel_q;
                if (sel_bvalid_s) begin
                    bresp_d  = sel_bresp_s;
                    bvalid_d = 1'b1;
                    state_d  = MRESP;
                end else begin
                    state_d = RESP;
                end
            end
            DERR: begin
                // Sink both channels locally; slaves never see this transaction.
                m_awready_s = ~aw_done_q;
                m_wready_s  = ~w_done_q;
                aw_done_d   = aw_done_q | (i_m_awvalid & m_awready_s);
                w_done_d    = w_done_q | (i_m_wvalid & m_wready_s);
                if (aw_done_d && w_done_d) begin
                    bresp_d  = RESP_DECERR;
                    bvalid_d = 1'b1;
                    cnt_d    = (&cnt_q) ? cnt_q : (cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1});
                    state_d  = MRESP;
                end else begin
                    state_d = DERR;
                end
            end
            MRESP: begin
                if (i_m_bready) begin
                    bvalid_d  = 1'b0;
                    sel_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = MRESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_write_router.sv
// Directed self-checking bench for axi_lite_write_router (3 slaves, 32-bit).
module tb_axi_lite_write_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_slave_select;
    logic [31:0] i_m_awaddr;
    logic        i_m_awvalid;
    logic        o_m_awready;
    logic [31:0] i_m_wdata;
    logic [3:0]  i_m_wstrb;
    logic        i_m_wvalid;
    logic        o_m_wready;
    logic [1:0]  o_m_bresp;
    logic        o_m_bvalid;
    logic        i_m_bready;
    logic [31:0] o_s_awaddr;
    logic [2:0]  o_s_awvalid;
    logic [2:0]  i_s_awready;
    logic [31:0] o_s_wdata;
    logic [3:0]  o_s_wstrb;
    logic [2:0]  o_s_wvalid;
    logic [2:0]  i_s_wready;
    logic [5:0]  i_s_bresp;
    logic [2:0]  i_s_bvalid;
    logic [2:0]  o_s_bready;
    logic [7:0]  o_decerr_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_lite_write_router dut (
        .clk            (clk),
        .reset          (reset),
        .i_slave_select (i_slave_select),
        .i_m_awaddr     (i_m_awaddr),
        .i_m_awvalid    (i_m_awvalid),
        .o_m_awready    (o_m_awready),
        .i_m_wdata      (i_m_wdata),
        .i_m_wstrb      (i_m_wstrb),
        .i_m_wvalid     (i_m_wvalid),
        .o_m_wready     (o_m_wready),
        .o_m_bresp      (o_m_bresp),
        .o_m_bvalid     (o_m_bvalid),
        .i_m_bready     (i_m_bready),
        .o_s_awaddr     (o_s_awaddr),
        .o_s_awvalid    (o_s_awvalid),
        .i_s_awready    (i_s_awready),
        .o_s_wdata      (o_s_wdata),
        .o_s_wstrb      (o_s_wstrb),
        .o_s_wvalid     (o_s_wvalid),
        .i_s_wready     (i_s_wready),
        .i_s_bresp      (i_s_bresp),
        .i_s_bvalid     (i_s_bvalid),
        .o_s_bready     (o_s_bready),
        .o_decerr_cnt   (o_decerr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One locally-answered DECERR transaction, AW and W offered together.
    task automatic do_decerr(input logic [2:0] sel);
        i_slave_select = sel;
        i_m_awvalid    = 1'b1;
        i_m_wvalid     = 1'b1;
        tick();
        tick();
        tick();
        i_m_awvalid = 1'b0;
        i_m_wvalid  = 1'b0;
        for (int k = 0; k < 8 && !o_m_bvalid; k++) tick();
        check_eq("derr_bvalid", {31'd0, o_m_bvalid}, 32'd1);
        i_m_bready = 1'b1;
        tick();
        i_m_bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_slave_select = 3'b000;
        i_m_awaddr = 32'd0;  i_m_awvalid = 1'b0;
        i_m_wdata  = 32'd0;  i_m_wstrb   = 4'h0;  i_m_wvalid = 1'b0;
        i_m_bready = 1'b0;
        i_s_awready = 3'b000; i_s_wready = 3'b000;
        i_s_bresp = 6'b0;     i_s_bvalid = 3'b000;
        tick();
        tick();
        check_eq("rst_bvalid",  {31'd0, o_m_bvalid}, 32'd0);
        check_eq("rst_bresp",   {30'd0, o_m_bresp}, 32'd0);
        check_eq("rst_cnt",     {24'd0, o_decerr_cnt}, 32'd0);
        check_eq("rst_awready", {31'd0, o_m_awready}, 32'd0);
        reset = 1'b0;

        // Slave 1, AW accepted 2 cycles into FWD; slave 0 drives a decoy B.
        i_slave_select = 3'b010;
        i_m_awaddr = 32'h0111_1111; i_m_awvalid = 1'b1;
        i_m_wdata  = 32'hCAFE_F00D; i_m_wstrb = 4'hF; i_m_wvalid = 1'b1;
        #1;
        check_eq("t1_idle_awrdy", {31'd0, o_m_awready}, 32'd0);
        check_eq("t1_idle_awv",   {29'd0, o_s_awvalid}, 32'd0);
        tick();
        check_eq("t1_dec_awv",    {29'd0, o_s_awvalid}, 32'd0);
        tick();
        check_eq("t1_fwd_awv",    {29'd0, o_s_awvalid}, 32'h2);
        check_eq("t1_fwd_wv",     {29'd0, o_s_wvalid}, 32'h2);
        check_eq("t1_awaddr",     o_s_awaddr, 32'h0111_1111);
        check_eq("t1_wdata",      o_s_wdata, 32'hCAFE_F00D);
        check_eq("t1_awrdy0",     {31'd0, o_m_awready}, 32'd0);
        i_s_wready = 3'b111;
        #1;
        check_eq("t1_wrdy",       {31'd0, o_m_wready}, 32'd1);
        tick();
        i_s_wready = 3'b000;
        #1;
        check_eq("t1_wv_done",    {29'd0, o_s_wvalid}, 32'd0);
        check_eq("t1_awv_hold",   {29'd0, o_s_awvalid}, 32'h2);
        tick();
        i_s_awready = 3'b010;
        #1;
        check_eq("t1_awrdy",      {31'd0, o_m_awready}, 32'd1);
        tick();
        i_s_awready = 3'b000; i_m_awvalid = 1'b0; i_m_wvalid = 1'b0;
        #1;
        check_eq("t1_bready",     {29'd0, o_s_bready}, 32'h2);
        check_eq("t1_awv_off",    {29'd0, o_s_awvalid}, 32'd0);
        i_s_bvalid = 3'b011; i_s_bresp = 6'b00_00_10;
        tick();
        i_s_bvalid = 3'b000;
        check_eq("t1_mbvalid",    {31'd0, o_m_bvalid}, 32'd1);
        check_eq("t1_mbresp",     {30'd0, o_m_bresp}, 32'd0);
        i_m_bready = 1'b1;
        tick();
        i_m_bready = 1'b0;
        check_eq("t1_bv_clr",     {31'd0, o_m_bvalid}, 32'd0);

        // Slave 0, W offered 3 cycles before AW; early slave B must be ignored.
        i_m_wvalid = 1'b1; i_s_wready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t2_idle_wrdy", {31'd0, o_m_wready}, 32'd0);
            tick();
        end
        i_m_awvalid = 1'b1; i_slave_select = 3'b001;
        tick();
        tick();
        check_eq("t2_fwd_wrdy",   {31'd0, o_m_wready}, 32'd1);
        check_eq("t2_fwd_awrdy",  {31'd0, o_m_awready}, 32'd0);
        check_eq("t2_fwd_awv",    {29'd0, o_s_awvalid}, 32'h1);
        tick();
        i_m_wvalid = 1'b0; i_s_wready = 3'b000;
        i_s_bvalid = 3'b001; i_s_bresp = 6'b00_00_10;
        #1;
        check_eq("t2_early_brdy", {29'd0, o_s_bready}, 32'd0);
        tick();
        check_eq("t2_early_bv",   {31'd0, o_m_bvalid}, 32'd0);
        i_s_awready = 3'b001;
        tick();
        i_s_awready = 3'b000; i_m_awvalid = 1'b0;
        #1;
        check_eq("t2_resp_brdy",  {29'd0, o_s_bready}, 32'h1);
        tick();
        i_s_bvalid = 3'b000;
        check_eq("t2_mbresp",     {30'd0, o_m_bresp}, 32'h2);
        i_m_awvalid = 1'b1; i_slave_select = 3'b001; i_s_awready = 3'b111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t2_hold_bv",   {31'd0, o_m_bvalid}, 32'd1);
            check_eq("t2_hold_br",   {30'd0, o_m_bresp}, 32'h2);
            check_eq("t2_hold_awrd", {31'd0, o_m_awready}, 32'd0);
            check_eq("t2_hold_awv",  {29'd0, o_s_awvalid}, 32'd0);
        end
        i_m_awvalid = 1'b0; i_s_awready = 3'b000; i_m_bready = 1'b1;
        tick();
        i_m_bready = 1'b0;

        // Zero-hot select: DECERR, slaves untouched even with ready high.
        i_slave_select = 3'b000; i_m_awvalid = 1'b1; i_m_wvalid = 1'b1;
        i_s_awready = 3'b111; i_s_wready = 3'b111;
        tick();
        tick();
        check_eq("t3_awrdy",      {31'd0, o_m_awready}, 32'd1);
        check_eq("t3_wrdy",       {31'd0, o_m_wready}, 32'd1);
        check_eq("t3_awv",        {29'd0, o_s_awvalid}, 32'd0);
        check_eq("t3_wv",         {29'd0, o_s_wvalid}, 32'd0);
        tick();
        i_m_awvalid = 1'b0; i_m_wvalid = 1'b0;
        check_eq("t3_bv",         {31'd0, o_m_bvalid}, 32'd1);
        check_eq("t3_bresp",      {30'd0, o_m_bresp}, 32'h3);
        check_eq("t3_cnt",        {24'd0, o_decerr_cnt}, 32'd1);
        i_m_bready = 1'b1;
        tick();
        i_m_bready = 1'b0;

        // Multi-hot select, AW before W.
        i_slave_select = 3'b011; i_m_awvalid = 1'b1;
        tick();
        tick();
        check_eq("t4_awv",        {29'd0, o_s_awvalid}, 32'd0);
        check_eq("t4_wrdy",       {31'd0, o_m_wready}, 32'd1);
        tick();
        i_m_awvalid = 1'b0;
        #1;
        check_eq("t4_awrdy_done", {31'd0, o_m_awready}, 32'd0);
        check_eq("t4_bv_wait",    {31'd0, o_m_bvalid}, 32'd0);
        i_m_wvalid = 1'b1;
        tick();
        i_m_wvalid = 1'b0;
        check_eq("t4_bresp",      {30'd0, o_m_bresp}, 32'h3);
        check_eq("t4_cnt",        {24'd0, o_decerr_cnt}, 32'd2);
        check_eq("t4_wv",         {29'd0, o_s_wvalid}, 32'd0);
        i_m_bready = 1'b1;
        tick();
        i_m_bready = 1'b0;
        i_s_awready = 3'b000; i_s_wready = 3'b000;

        // Async reset while slave 2 sees awvalid.
        i_slave_select = 3'b100; i_m_awvalid = 1'b1; i_m_wvalid = 1'b1;
        tick();
        tick();
        check_eq("t5_awv_pre",    {29'd0, o_s_awvalid}, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_awv",        {29'd0, o_s_awvalid}, 32'd0);
        check_eq("t5_wv",         {29'd0, o_s_wvalid}, 32'd0);
        check_eq("t5_awrdy",      {31'd0, o_m_awready}, 32'd0);
        check_eq("t5_cnt",        {24'd0, o_decerr_cnt}, 32'd0);
        i_m_awvalid = 1'b0; i_m_wvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_eq("t5_idle_awv",   {29'd0, o_s_awvalid}, 32'd0);

        // Saturation of the DECERR counter.
        for (int n = 0; n < 255; n++) do_decerr(3'b110);
        check_eq("t6_cnt255",     {24'd0, o_decerr_cnt}, 32'd255);
        do_decerr(3'b000);
        check_eq("t6_cnt_sat",    {24'd0, o_decerr_cnt}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
